interp_upsampler: RTL and testbench
===================================

// Module: interp_upsampler
// PURPOSE
//  Front stage of the interpolation chain; sits directly upstream of fir_direct_nom.
//  Accepts low-rate signed samples over a valid/ready handshake and buffers them in a small FIFO.
//  Emits one sample per clock at UP_FACTOR x the input rate: each input sample followed by UP_FACTOR-1 zeros.
//  Output drives the FIR data input, which consumes a sample every cycle.
// PARAMETERS
//  DATA_WIDTH  5  signed sample width, in and out
//  UP_FACTOR   4  interpolation ratio L; legal range 1..16
//  FIFO_DEPTH  4  input buffer entries; power of 2, >=2
// PORTS
//  clk        in   1                    rising-edge clock
//  rst        in   1                    synchronous, active-low reset
//  in_data    in   DATA_WIDTH (signed)  input sample
//  in_valid   in   1                    in_data valid
//  in_ready   out  1                    FIFO can accept; transfer when in_valid&&in_ready at posedge
//  out        out  DATA_WIDTH (signed)  upsampled stream to FIR
//  out_valid  out  1                    stream running (high from first emitted sample onward)
//  phase      out  $clog2(UP_FACTOR)+1  index of out within current L-group (0 = data slot)
//  underrun   out  1                    sticky: a data slot found the FIFO empty
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - out=0, out_valid=0, phase=0, underrun=0; FIFO emptied; state=IDLE.
//   - in_ready=0 during reset; in_ready=1 the cycle after release.
//  in_ready = !fifo_full, registered-count based; no same-cycle pass-through.
//  A push into a full FIFO cannot occur.
//  FSM IDLE:
//   - out=0, out_valid=0.
//   - FIFO non-empty at a posedge -> pop head; out<=head; phase<=0; out_valid<=1; go RUN.
//  FSM RUN (never returns to IDLE except via reset):
//   - phase<=(phase==UP_FACTOR-1)?0:phase+1 every cycle.
//   - Entering phase 0 with FIFO non-empty: pop; out<=head.
//   - Entering phase 0 with FIFO empty: out<=0; underrun<=1 (held until reset).
//   - Entering phase!=0: out<=0.
//  Latency:
//   - Sample accepted at edge k appears on out after edge k+2 when the FIFO was empty and state IDLE.
//   - Otherwise it appears at its scheduled data slot.
//  Simultaneous push and pop in one cycle are both honoured; count unchanged.
//  UP_FACTOR=1: phase stuck at 0; every RUN cycle is a data slot (rate-1 buffered pass-through).
//  Values pass bit-exact, no scaling or saturation: -16 and +15 are preserved at DATA_WIDTH=5.
//  Passband gain compensation (xL) is the FIR coefficients' job, not this block's.
//  FIFO pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
// CONFIGURATION
//  UPSAMPLER_HOLD_EN defined:
//   - Zero-order hold: non-data slots repeat the last emitted data sample instead of 0.
//   - Underrun slot also repeats the last sample; underrun still sets.
//   - Hold register is cleared by reset.
//  UPSAMPLER_HOLD_EN undefined: zero-stuffing exactly as above.
// STRUCTURE
//  interp_filt_pkg:
//   - upsampler_state_e {IDLE, RUN}
//   - width helpers (PHASE_W, CNT_W) as functions of parameters
//  Sub-module sync_fifo:
//   - parameters DATA_WIDTH, DEPTH; ports push/pop/full/empty/count; same clk/rst convention.
//   - Reused later ahead of the decimation path.
//  Top holds the FSM, phase counter, output register and underrun flag.
// TESTING (DATA_WIDTH=5, UP_FACTOR=4, FIFO_DEPTH=4)
//  1. rst=0 for 2 cycles -> out=0, out_valid=0, phase=0, underrun=0, in_ready=0; in_ready=1 after release.
//  2. Push 3 then -2 on consecutive cycles, then in_valid=0 -> out=3,0,0,0,-2,0,0,0 starting edge k+2;
//     next phase 0 gives out=0 and underrun=1, which stays 1.
//  3. in_valid held high with 1,2,3,... from release -> in_ready drops once FIFO holds 4 and pulses once per 4 cycles;
//     out=1,0,0,0,2,0,0,0,...; no sample lost or duplicated; underrun=0.
//  4. Push -16, 15, 0 -> data slots show -16, 15, 0 exactly.
//  5. rst=0 during RUN at phase 2 with 2 entries queued -> next cycle all outputs at reset values, FIFO empty;
//     after release push 7 -> out=7 at edge k+2, phase=0.
//  6. UPSAMPLER_HOLD_EN: push 5, 9, then stop -> out=5,5,5,5,9,9,9,9,9...; underrun=1 at the 3rd data slot.

Source files
------------

// File: rtl/interp_filt_pkg.sv
// Shared types and width helpers for the interpolation/decimation filter chain.
package interp_filt_pkg;

  typedef enum logic [0:0] {StIdle, StRun} upsampler_state_e;

  function automatic int unsigned phase_w(int unsigned up_factor);
    return $clog2(up_factor) + 1;
  endfunction

  function automatic int unsigned cnt_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count; synchronous active-low reset.
module sync_fifo
  import interp_filt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = cnt_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/interp_upsampler.sv
// Zero-stuffing L-times upsampler feeding the FIR; buffers input in a small FIFO.
// Define UPSAMPLER_HOLD_EN for zero-order hold instead of zero stuffing.
module interp_upsampler
  import interp_filt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned UP_FACTOR  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] out,
  output logic                         out_valid,
  output logic [$clog2(UP_FACTOR):0]   phase,
  output logic                         underrun
);

  localparam int unsigned PhaseW = phase_w(UP_FACTOR);
  localparam int unsigned CntW   = cnt_w(FIFO_DEPTH);
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(UP_FACTOR - 1);

  upsampler_state_e             state_q, state_d;
  logic [PhaseW-1:0]            phase_q, phase_d;
  logic signed [DATA_WIDTH-1:0] out_q, out_d, fill;
  logic                         out_valid_q, out_valid_d;
  logic                         underrun_q, underrun_d;
  logic                         start_q, start_d;
  logic                         rdy_q;
  logic                         fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0]        fifo_rdata;
  logic [CntW-1:0]              fifo_count;

  assign in_ready  = rdy_q && !fifo_full;
  assign fifo_push = in_valid && in_ready;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (in_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef UPSAMPLER_HOLD_EN
  assign fill = out_q;
`else
  assign fill = '0;
`endif

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    underrun_d  = underrun_q;
    start_d     = start_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // One-cycle start qualification: first sample leaves two edges after acceptance.
        start_d = (fifo_count != '0);
        if (start_q && !fifo_empty) begin
          fifo_pop    = 1'b1;
          out_d       = fifo_rdata;
          phase_d     = '0;
          out_valid_d = 1'b1;
          state_d     = StRun;
        end
      end
      StRun: begin
        phase_d = (phase_q == PhaseLast) ? '0 : phase_q + 1'b1;
        if (phase_d == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            out_d    = fifo_rdata;
          end else begin
            out_d      = fill;
            underrun_d = 1'b1;
          end
        end else begin
          out_d = fill;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      start_q     <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
      start_q     <= start_d;
      rdy_q       <= 1'b1;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign phase     = phase_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_interp_upsampler.sv
// Self-checking bench for interp_upsampler: queue-based reference model plus directed literals.
module tb_interp_upsampler;

  localparam int DW = 5;
  localparam int L  = 4;
  localparam int D  = 4;
`ifdef UPSAMPLER_HOLD_EN
  localparam bit Hold = 1'b1;
`else
  localparam bit Hold = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] out;
  logic                 out_valid;
  logic [2:0]           phase;
  logic                 underrun;

  interp_upsampler #(
    .DATA_WIDTH (DW),
    .UP_FACTOR  (L),
    .FIFO_DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .phase     (phase),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: samples queue, stream starts two edges after the first accepted
  // sample, then every L-th cycle is a data slot.
  int m_q[$];
  bit m_rdy   = 1'b0;
  bit m_run   = 1'b0;
  int m_t     = 0;
  int m_out   = 0;
  bit m_valid = 1'b0;
  bit m_under = 1'b0;
  int m_edge  = 0;
  int m_first = -1;

  task automatic model_step();
    bit acc;
    int d;
    m_edge++;
    if (!rst) begin
      m_q.delete();
      m_rdy = 1'b0; m_run = 1'b0; m_t = 0; m_out = 0;
      m_valid = 1'b0; m_under = 1'b0; m_first = -1;
    end else begin
      acc = in_valid && m_rdy && (m_q.size() < D);
      d   = int'(in_data);
      if (m_run) begin
        m_t = (m_t + 1) % L;
        if (m_t == 0) begin
          if (m_q.size() > 0) m_out = m_q.pop_front();
          else begin
            m_under = 1'b1;
            if (!Hold) m_out = 0;
          end
        end else if (!Hold) begin
          m_out = 0;
        end
      end else if (m_first >= 0 && m_edge == m_first + 2) begin
        m_run = 1'b1; m_t = 0; m_valid = 1'b1;
        m_out = m_q.pop_front();
      end
      if (acc) begin
        m_q.push_back(d);
        if (m_first < 0) m_first = m_edge;
      end
      m_rdy = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("model_out", int'(out), m_out);
    check("model_out_valid", int'(out_valid), int'(m_valid));
    check("model_phase", int'(phase), m_t);
    check("model_underrun", int'(underrun), int'(m_under));
    check("model_in_ready", int'(in_ready), int'(m_rdy && (m_q.size() < D)));
  endtask

  always @(posedge clk) model_step();
  always @(negedge clk) if (chk_en) compare_all();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  int next_exp;
  int acc_cnt;
  bit acc;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0;

    // 1. Reset state
    tick();
    chk_en = 1'b1;
    tick();
    check("t1_out", int'(out), 0);
    check("t1_out_valid", int'(out_valid), 0);
    check("t1_phase", int'(phase), 0);
    check("t1_underrun", int'(underrun), 0);
    check("t1_in_ready", int'(in_ready), 0);
    rst = 1'b1;
    tick();
    check("t1_in_ready_release", int'(in_ready), 1);

    // 2. Two samples then starve
    in_valid = 1'b1; in_data = 5'sd3;
    tick();
    in_data = -5'sd2;
    tick();
    in_valid = 1'b0;
    tick();
    check("t2_slot0_out", int'(out), 3);
    check("t2_slot0_phase", int'(phase), 0);
    check("t2_slot0_valid", int'(out_valid), 1);
    tick();
    check("t2_gap_out", int'(out), Hold ? 3 : 0);
    check("t2_gap_phase", int'(phase), 1);
    repeat (3) tick();
    check("t2_slot1_out", int'(out), -2);
    check("t2_slot1_underrun", int'(underrun), 0);
    repeat (4) tick();
    check("t2_slot2_out", int'(out), Hold ? -2 : 0);
    check("t2_slot2_underrun", int'(underrun), 1);
    repeat (4) tick();
    check("t2_underrun_sticky", int'(underrun), 1);

    // 3. Continuous input: back-pressure, ordering, no loss
    do_reset();
    in_valid = 1'b1; in_data = 5'sd1;
    next_exp = 1;
    acc_cnt  = 0;
    for (int i = 0; i < 40; i++) begin
      acc = in_ready;
      tick();
      if (acc) in_data = in_data + 1'b1;
      if (i >= 24 && acc) acc_cnt++;
      if (out_valid && phase == 3'd0) begin
        check("t3_order", int'(out), next_exp);
        next_exp++;
      end
    end
    in_valid = 1'b0;
    check("t3_accepts_per_16", acc_cnt, 4);
    check("t3_underrun", int'(underrun), 0);

    // 4. Extreme values pass bit-exact
    do_reset();
    in_valid = 1'b1; in_data = -5'sd16;
    tick();
    in_data = 5'sd15;
    tick();
    in_data = 5'sd0;
    tick();
    in_valid = 1'b0;
    check("t4_min", int'(out), -16);
    repeat (4) tick();
    check("t4_max", int'(out), 15);
    repeat (4) tick();
    check("t4_zero", int'(out), 0);
    check("t4_no_underrun", int'(underrun), 0);

    // 5. Reset mid-run with entries queued
    do_reset();
    in_valid = 1'b1; in_data = 5'sd10;
    tick();
    in_data = 5'sd11;
    tick();
    in_data = 5'sd12;
    tick();
    in_valid = 1'b0;
    check("t5_first", int'(out), 10);
    repeat (2) tick();
    check("t5_phase2", int'(phase), 2);
    rst = 1'b0;
    tick();
    check("t5_rst_out", int'(out), 0);
    check("t5_rst_valid", int'(out_valid), 0);
    check("t5_rst_phase", int'(phase), 0);
    check("t5_rst_in_ready", int'(in_ready), 0);
    rst = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 5'sd7;
    tick();
    in_valid = 1'b0;
    check("t5_idle_valid", int'(out_valid), 0);
    tick();
    check("t5_not_yet", int'(out_valid), 0);
    tick();
    check("t5_seven", int'(out), 7);
    check("t5_seven_phase", int'(phase), 0);
    repeat (4) tick();
    check("t5_fifo_flushed", int'(underrun), 1);

`ifdef UPSAMPLER_HOLD_EN
    // 6. Zero-order hold
    do_reset();
    in_valid = 1'b1; in_data = 5'sd5;
    tick();
    in_data = 5'sd9;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("t6_hold", int'(out), (i < 4) ? 5 : 9);
      check("t6_underrun", int'(underrun), (i == 8) ? 1 : 0);
    end
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
